// File: rtl/riscv_pkg.sv
// Shared core-wide widths, fetch FSM encoding and PC alignment mask.
package riscv_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    localparam logic [XLEN-1:0] PC_ALIGN_MASK = ~64'h3;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        HOLD,
        DROP
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter: reset load, redirect load (word-aligned) over sequential increment.
module fetch_pc_reg
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inc,
    input  logic            load,
    input  logic [XLEN-1:0] load_pc,
    output logic [XLEN-1:0] pc
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_pc & PC_ALIGN_MASK;
        end else if (inc) begin
            pc <= pc + XLEN'(PC_STEP);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding imem requests, stall holding and
// redirect handling, feeding the IF/ID buffer.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_0000_0000,
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [ILEN-1:0] imem_resp_data,
    output logic [ILEN-1:0] nextInstruc,
    output logic [XLEN-1:0] nextPC,
    output logic            e_write,
    output logic            IF_flush
);

    fetch_state_t    state, state_nx;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inflight_pc;
    logic [ILEN-1:0] hold_instr;
    logic [XLEN-1:0] hold_pc;
    logic            pc_inc;
    logic            cap_inflight;
    logic            cap_hold;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (pc_inc),
        .load    (redirect_valid),
        .load_pc (redirect_pc),
        .pc      (pc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= REQ;
            inflight_pc <= '0;
            hold_instr  <= '0;
            hold_pc     <= '0;
        end else begin
            state <= state_nx;
            if (cap_inflight) begin
                inflight_pc <= pc;
            end
            if (cap_hold) begin
                hold_instr <= imem_resp_data;
                hold_pc    <= inflight_pc;
            end
        end
    end

    always_comb begin
        state_nx       = state;
        imem_req_valid = 1'b0;
        imem_req_addr  = '0;
        nextInstruc    = '0;
        nextPC         = '0;
        e_write        = 1'b0;
        IF_flush       = 1'b0;
        pc_inc         = 1'b0;
        cap_inflight   = 1'b0;
        cap_hold       = 1'b0;

        case (state)
            REQ: begin
                imem_req_valid = 1'b1;
                imem_req_addr  = pc;
                if (imem_req_ready) begin
                    cap_inflight = 1'b1;
                    state_nx     = WAIT;
                end
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    if (!stall) begin
                        e_write     = 1'b1;
                        nextInstruc = imem_resp_data;
                        nextPC      = inflight_pc;
                        pc_inc      = 1'b1;
                        state_nx    = REQ;
                    end else begin
                        cap_hold = 1'b1;
                        state_nx = HOLD;
                    end
                end
            end
            HOLD: begin
                nextInstruc = hold_instr;
                nextPC      = hold_pc;
                e_write     = ~stall;
                if (!stall) begin
                    pc_inc   = 1'b1;
                    state_nx = REQ;
                end
            end
            DROP: begin
                if (imem_resp_valid) begin
                    state_nx = REQ;
                end
            end
            default: state_nx = REQ;
        endcase

        // Redirect overrides any handover; a response still owed after it must be drained in DROP.
        if (redirect_valid) begin
            IF_flush    = 1'b1;
            e_write     = 1'b0;
            nextInstruc = '0;
            nextPC      = '0;
            pc_inc      = 1'b0;
            cap_hold    = 1'b0;
            case (state)
                REQ:     state_nx = imem_req_ready ? DROP : REQ;
                WAIT:    state_nx = imem_resp_valid ? REQ : DROP;
                HOLD:    state_nx = REQ;
                DROP:    state_nx = imem_resp_valid ? REQ : DROP;
                default: state_nx = REQ;
            endcase
        end

        if (!rst_n) begin
            imem_req_valid = 1'b0;
            imem_req_addr  = '0;
            nextInstruc    = '0;
            nextPC         = '0;
            e_write        = 1'b0;
            IF_flush       = 1'b0;
        end
    end

endmodule
